// File: rtl/data_mem_ctrl.sv
// Byte-wide data memory controller with fixed write latency and RD_LAT-cycle reads.
// Define DMEM_ADDR_CHECK_EN to enable out-of-range detection (MEM_ERR, write suppression).
module data_mem_ctrl #(
    parameter int DEPTH  = 65536,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [18:0] dm_addr,
    input  logic [7:0]  dm_data,
    output logic [7:0]  mem_data,
    output logic        MEM_RDY,
    output logic        MEM_WACK,
    output logic        MEM_BUSY,
    output logic        MEM_ERR
);
    localparam int         AW     = $clog2(DEPTH);
    localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);
`ifdef DMEM_ADDR_CHECK_EN
    localparam logic [19:0] DEPTH_W = 20'(DEPTH);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_lat_cnt;
    logic [2:0]  w_lat_cnt_nxt;
    logic [18:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_mem [DEPTH];

    logic [7:0]  r_mem_data;
    logic        r_mem_rdy;
    logic        r_mem_wack;
    logic        r_mem_busy;
    logic        r_mem_err;

    logic        w_accept;
    logic        w_acc_wr;
    logic        w_acc_rd;
    logic [18:0] w_rsp_addr;
    logic [AW-1:0] w_idx;
    logic        w_oor;
    logic        w_commit;
    logic        w_rdy_nxt;
    logic        w_wack_nxt;
    logic        w_busy_nxt;
    logic        w_err_nxt;
    logic        w_unused_addr;

    // The response cycle doubles as an acceptance slot so requests can run back-to-back.
    assign w_accept = ((r_state == IDLE) || (r_state == RESP)) && (MEM_READ || MEM_WRITE);
    assign w_acc_wr = w_accept && MEM_WRITE;
    assign w_acc_rd = w_accept && !MEM_WRITE;

    // A single-cycle read completes straight from the live inputs; otherwise the latched address applies.
    assign w_rsp_addr    = ((r_state == IDLE) || (r_state == RESP)) ? dm_addr : r_addr;
    assign w_idx         = w_rsp_addr[AW-1:0];
    assign w_unused_addr = ^w_rsp_addr;

`ifdef DMEM_ADDR_CHECK_EN
    assign w_oor = ({1'b0, w_rsp_addr} >= DEPTH_W);
`else
    assign w_oor = 1'b0;
`endif

    assign w_commit = (r_state == WR) && !RST && !w_oor;

    // State and latency counter register
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state   <= IDLE;
            r_lat_cnt <= 3'd0;
        end else begin
            r_state   <= w_next_state;
            r_lat_cnt <= w_lat_cnt_nxt;
        end
    end

    // Next-state and counter logic
    always_comb begin
        w_next_state  = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        case (r_state)
            IDLE, RESP: begin
                if (w_acc_wr) begin
                    w_next_state  = WR;
                    w_lat_cnt_nxt = 3'd0;
                end else if (w_acc_rd) begin
                    w_lat_cnt_nxt = LAT_M1;
                    w_next_state  = (LAT_M1 == 3'd0) ? RESP : RD_WAIT;
                end else begin
                    w_next_state  = IDLE;
                    w_lat_cnt_nxt = 3'd0;
                end
            end
            RD_WAIT: begin
                w_lat_cnt_nxt = r_lat_cnt - 3'd1;
                if (r_lat_cnt == 3'd1) begin
                    w_next_state = RESP;
                end else begin
                    w_next_state = RD_WAIT;
                end
            end
            WR: begin
                w_next_state = RESP;
            end
            default: begin
                w_next_state  = IDLE;
                w_lat_cnt_nxt = 3'd0;
            end
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_wack_nxt = (r_state == WR);
        w_rdy_nxt  = ((r_state == RD_WAIT) && (r_lat_cnt == 3'd1)) ||
                     (w_acc_rd && (LAT_M1 == 3'd0));
        w_busy_nxt = (w_next_state != IDLE);
`ifdef DMEM_ADDR_CHECK_EN
        w_err_nxt  = (w_rdy_nxt || w_wack_nxt) && w_oor;
`else
        w_err_nxt  = 1'b0;
`endif
    end

    // Request capture
    always_ff @(posedge clk) begin
        if (RST) begin
            r_addr  <= 19'd0;
            r_wdata <= 8'd0;
        end else if (w_accept) begin
            r_addr  <= dm_addr;
            r_wdata <= dm_data;
        end else begin
            r_addr  <= r_addr;
            r_wdata <= r_wdata;
        end
    end

    // Storage array, deliberately without reset
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (RST) begin
            r_mem_data <= 8'h00;
            r_mem_rdy  <= 1'b0;
            r_mem_wack <= 1'b0;
            r_mem_busy <= 1'b0;
            r_mem_err  <= 1'b0;
        end else begin
            r_mem_rdy  <= w_rdy_nxt;
            r_mem_wack <= w_wack_nxt;
            r_mem_busy <= w_busy_nxt;
            r_mem_err  <= w_err_nxt;
            if (w_rdy_nxt) begin
                r_mem_data <= w_oor ? 8'h00 : r_mem[w_idx];
            end
        end
    end

    assign mem_data = r_mem_data;
    assign MEM_RDY  = r_mem_rdy;
    assign MEM_WACK = r_mem_wack;
    assign MEM_BUSY = r_mem_busy;
    assign MEM_ERR  = r_mem_err;

endmodule
